uart_rx: RTL and testbench

UART receiver that sits downstream of the UART transmitter. It consumes the serial line the transmitter drives (idle-high; start bit, data LSB-first, optional parity, one stop bit). It oversamples each bit Prescale times in the single clk domain and majority-votes the mid-bit samples. It delivers the parallel byte with a one-cycle valid strobe plus parity/stop error strobes.

---
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: oversamples each serial bit Prescale times, majority-votes the
// three mid-bit samples, and emits the received word with one-cycle status strobes.
module uart_rx #(
    parameter int unsigned Data_Width = 8,
    parameter int unsigned Prescale   = 8
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  RX_In,
    input  logic                  Par_En,
    input  logic                  Par_Type,
    output logic [Data_Width-1:0] P_Data,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stop_Err
);

    localparam int unsigned CW = (Prescale > 2) ? $clog2(Prescale) : 1;
    localparam int unsigned BW = (Data_Width > 1) ? $clog2(Data_Width) : 1;

    localparam logic [CW-1:0] LastEdge = CW'(Prescale - 1);
    localparam logic [CW-1:0] SampLo   = CW'(Prescale / 2 - 1);
    localparam logic [CW-1:0] SampMid  = CW'(Prescale / 2);
    localparam logic [CW-1:0] SampHi   = CW'(Prescale / 2 + 1);
    localparam logic [BW-1:0] LastBit  = BW'(Data_Width - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

    state_t                state;
    logic [CW-1:0]         edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [2:0]            samp;
    logic [Data_Width-1:0] shift;
    logic                  par_en_l;
    logic                  par_type_l;
    logic                  par_err;
    logic                  decision;
    logic                  s_hi;
    logic                  vote;

    // Majority vote; with Prescale=4 the last sample lands on the decision cycle itself,
    // so the live line value stands in for the not-yet-registered third sample.
    always_comb begin
        decision = (edge_cnt == LastEdge);
        s_hi     = (edge_cnt == SampHi) ? RX_In : samp[2];
        vote     = (samp[0] & samp[1]) | (samp[0] & s_hi) | (samp[1] & s_hi);
    end

    // Frame FSM, counters, sampling and registered output strobes.
    always_ff @(posedge clk) begin
        if (RST) begin
            state      <= StIdle;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            samp       <= '0;
            shift      <= '0;
            par_en_l   <= 1'b0;
            par_type_l <= 1'b0;
            par_err    <= 1'b0;
            P_Data     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;

            if (state != StIdle) begin
                if (edge_cnt == SampLo)  samp[0] <= RX_In;
                if (edge_cnt == SampMid) samp[1] <= RX_In;
                if (edge_cnt == SampHi)  samp[2] <= RX_In;
                edge_cnt <= decision ? '0 : edge_cnt + CW'(1);
            end

            case (state)
                StIdle: begin
                    // The detecting cycle already counts as edge 0 of the start bit.
                    if (!RX_In) begin
                        state      <= StStart;
                        edge_cnt   <= CW'(1);
                        bit_cnt    <= '0;
                        par_en_l   <= Par_En;
                        par_type_l <= Par_Type;
                        par_err    <= 1'b0;
                    end
                end
                StStart: begin
                    if (decision) state <= vote ? StIdle : StData;
                end
                StData: begin
                    if (decision) begin
                        shift <= Data_Width'({vote, shift} >> 1);
                        if (bit_cnt == LastBit) begin
                            bit_cnt <= '0;
                            state   <= par_en_l ? StParity : StStop;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                StParity: begin
                    if (decision) begin
                        par_err <= (vote != (^shift ^ par_type_l));
                        state   <= StStop;
                    end
                end
                StStop: begin
                    if (decision) begin
                        if (!par_err && vote) begin
                            P_Data     <= shift;
                            Data_Valid <= 1'b1;
                        end
                        Par_Err  <= par_err;
                        Stop_Err <= !vote;
                        state    <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, randomized frames checked
// against a frame-level model, and hand sequences for glitch, back-to-back and reset.
module tb_uart_rx;

    localparam int unsigned DW = 8;
    localparam int unsigned PS = 8;

    logic          clk = 1'b0;
    logic          RST;
    logic          RX_In;
    logic          Par_En;
    logic          Par_Type;
    logic [DW-1:0] P_Data;
    logic          Data_Valid;
    logic          Par_Err;
    logic          Stop_Err;

    uart_rx #(.Data_Width(DW), .Prescale(PS)) dut (
        .clk       (clk),
        .RST       (RST),
        .RX_In     (RX_In),
        .Par_En    (Par_En),
        .Par_Type  (Par_Type),
        .P_Data    (P_Data),
        .Data_Valid(Data_Valid),
        .Par_Err   (Par_Err),
        .Stop_Err  (Stop_Err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int tick_no = 0;

    // Strobe log for the current observation window.
    int            n_strobe = 0;
    int            s_tick;
    logic          s_dv, s_pe, s_se;
    logic [DW-1:0] s_pd;
    logic [DW-1:0] model_pd = '0;

    typedef struct {
        logic [DW-1:0] data;
        logic          pen;
        logic          ptype;
        logic          par_flip;
        logic          stop_bit;
        int            noise_bit;
        logic          exp_dv;
        logic          exp_pe;
        logic          exp_se;
        logic [DW-1:0] exp_pd;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive the line, then look at outputs just after the edge.
    task automatic tick(input logic b);
        RX_In = b;
        @(posedge clk);
        #1;
        tick_no++;
        if (Data_Valid || Par_Err || Stop_Err) begin
            n_strobe++;
            s_tick = tick_no;
            s_dv   = Data_Valid;
            s_pe   = Par_Err;
            s_se   = Stop_Err;
            s_pd   = P_Data;
        end
        if (!Data_Valid) check("p_data_stable", P_Data, model_pd);
    endtask

    // Send one frame; optional single-cycle inversion at (noise_bit, noise_off).
    task automatic send_frame(input logic [DW-1:0] data, input logic pen, input logic ptype,
                              input logic par_flip, input logic stop_bit,
                              input int noise_bit, input int noise_off,
                              input logic exp_dv, input logic exp_pe, input logic exp_se,
                              input logic [DW-1:0] exp_pd, input string tag);
        logic bits[$];
        int   start;
        logic v;
        bits.push_back(1'b0);
        for (int i = 0; i < int'(DW); i++) bits.push_back(data[i]);
        if (pen) bits.push_back((^data ^ ptype) ^ par_flip);
        bits.push_back(stop_bit);
        Par_En   = pen;
        Par_Type = ptype;
        n_strobe = 0;
        start    = tick_no;
        for (int i = 0; i < bits.size(); i++) begin
            for (int j = 0; j < int'(PS); j++) begin
                v = bits[i];
                if (i == noise_bit && j == noise_off) v = ~v;
                tick(v);
                // Mid-frame changes of the parity controls must be ignored.
                if (i == 0 && j == 0) begin
                    Par_En   = ~pen;
                    Par_Type = ~ptype;
                end
            end
        end
        check({tag, " strobes"}, n_strobe, 1);
        check({tag, " latency"}, s_tick - start, bits.size() * PS);
        check({tag, " dv"}, s_dv, exp_dv);
        check({tag, " par_err"}, s_pe, exp_pe);
        check({tag, " stop_err"}, s_se, exp_se);
        check({tag, " p_data"}, s_pd, exp_pd);
        model_pd = exp_pd;
    endtask

    initial begin
        int            dv_a, dv_b;
        logic [DW-1:0] d;
        logic          pen, pty, flip, stp, e_pe, e_se, e_dv;
        int            nb, noff, nbits;

        vecs[0] = '{8'hA5, 0, 0, 0, 1, -1, 1, 0, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1, 0, 0, 1, -1, 1, 0, 0, 8'h3C};
        vecs[2] = '{8'h3C, 1, 1, 0, 1, -1, 1, 0, 0, 8'h3C};
        vecs[3] = '{8'h5A, 0, 0, 0, 1, -1, 1, 0, 0, 8'h5A};
        vecs[4] = '{8'h3C, 1, 0, 1, 1, -1, 0, 1, 0, 8'h5A};
        vecs[5] = '{8'h55, 0, 0, 0, 0, -1, 0, 0, 1, 8'h5A};
        vecs[6] = '{8'h0F, 0, 0, 0, 1, -1, 1, 0, 0, 8'h0F};
        vecs[7] = '{8'hC3, 1, 1, 1, 0, -1, 0, 1, 1, 8'h0F};
        vecs[8] = '{8'h96, 0, 0, 0, 1,  4, 1, 0, 0, 8'h96};

        RST = 1'b1; RX_In = 1'b1; Par_En = 1'b0; Par_Type = 1'b0;
        tick(1'b1);
        tick(1'b1);
        check("reset p_data", P_Data, 0);
        check("reset dv", Data_Valid, 0);
        check("reset par_err", Par_Err, 0);
        check("reset stop_err", Stop_Err, 0);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b1);

        for (int k = 0; k < 9; k++) begin
            send_frame(vecs[k].data, vecs[k].pen, vecs[k].ptype, vecs[k].par_flip,
                       vecs[k].stop_bit, vecs[k].noise_bit, PS / 2,
                       vecs[k].exp_dv, vecs[k].exp_pe, vecs[k].exp_se, vecs[k].exp_pd,
                       $sformatf("vec%0d", k));
        end

        // Two-cycle low glitch, then a frame right after the 8-cycle rejection window.
        n_strobe = 0;
        tick(1'b0);
        tick(1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1);
        check("glitch strobes", n_strobe, 0);
        send_frame(8'h81, 0, 0, 0, 1, -1, 0, 1, 0, 0, 8'h81, "post_glitch");

        // Back-to-back frames with no gap.
        send_frame(8'h01, 0, 0, 0, 1, -1, 0, 1, 0, 0, 8'h01, "b2b_a");
        dv_a = s_tick;
        send_frame(8'hFF, 0, 0, 0, 1, -1, 0, 1, 0, 0, 8'hFF, "b2b_b");
        dv_b = s_tick;
        check("b2b spacing", dv_b - dv_a, 80);

        // Reset 30 cycles into a frame aborts it silently.
        n_strobe = 0;
        d = 8'h77;
        for (int c = 0; c < 30; c++) tick((c < int'(PS)) ? 1'b0 : d[c / int'(PS) - 1]);
        RST = 1'b1;
        model_pd = '0;
        tick(1'b1);
        check("midreset p_data", P_Data, 0);
        check("midreset dv", Data_Valid, 0);
        RST = 1'b0;
        for (int i = 0; i < 100; i++) tick(1'b1);
        check("midreset strobes", n_strobe, 0);
        send_frame(8'hE7, 1, 1, 0, 1, -1, 0, 1, 0, 0, 8'hE7, "post_reset");

        // Random frames against the frame-level model.
        for (int k = 0; k < 40; k++) begin
            d     = DW'($urandom);
            pen   = 1'($urandom);
            pty   = 1'($urandom);
            flip  = ($urandom_range(0, 3) == 0);
            stp   = ($urandom_range(0, 3) != 0);
            nbits = 2 + int'(DW) + int'(pen);
            nb    = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, nbits - 1));
            noff  = int'(PS / 2 - 1) + int'($urandom_range(0, 2));
            e_pe  = pen & flip;
            e_se  = ~stp;
            e_dv  = ~e_pe & ~e_se;
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) tick(1'b1);
            send_frame(d, pen, pty, flip, stp, nb, noff, e_dv, e_pe, e_se,
                       e_dv ? d : model_pd, $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
